// File: rtl/tt_char_pkg.sv
// Shared types and constants for the truth-table characterizer.
// Optional build macro: TT_MAJORITY_VOTE_EN (3-cycle majority-vote sampling).
package tt_char_pkg;

  localparam int NUM_INPUTS = 3;
  localparam int NUM_COMBOS = 8;
  localparam int CODE_W     = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    FINISH = 2'd3
  } state_e;

  // 2-of-3 majority used to filter single-cycle glitches on the gate output
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/tt_settle_timer.sv
// Settle countdown: load preset, count down while enabled, expire on the
// last counted cycle so the FSM leaves SETTLE on the following edge.
module tt_settle_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         expire_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // next count: preload has priority, stop at zero
  always_comb begin
    cnt_d = cnt_q;
    if (load_i)                          cnt_d = load_val_i;
    else if (en_i && (cnt_q != '0))      cnt_d = cnt_q - 1'b1;
  end

  // counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign expire_o = en_i && (cnt_q == W'(1));

endmodule

// File: rtl/tt_characterizer.sv
// Sweeps all 8 input combinations of a 3-input gate, waits SETTLE_CYCLES per
// combination, samples the gate output and assembles an 8-bit truth-table
// code (input 000 -> code[7], input 111 -> code[0]).
// Optional build macro: TT_MAJORITY_VOTE_EN -- each sample spans 3 cycles and
// the stored bit is the majority of the three observations.
module tt_characterizer
  import tt_char_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  output logic [NUM_INPUTS-1:0] dut_in,
  input  logic                  dut_out,
  output logic                  busy,
  output logic                  done,
  output logic [CODE_W-1:0]     code,
  output logic                  valid
);

  localparam logic [7:0]            SETTLE_LD = 8'(SETTLE_CYCLES);
  localparam logic [NUM_INPUTS-1:0] LAST_IDX  = NUM_INPUTS'(NUM_COMBOS - 1);

  state_e                  state_q;
  logic [NUM_INPUTS-1:0]   idx_q;
  logic [NUM_INPUTS-1:0]   dut_in_q;
  logic                    busy_q;
  logic                    done_q;
  logic                    valid_q;
  logic [CODE_W-1:0]       code_q;

  logic                    settle_expire;
  logic                    sample_last;
  logic                    sample_bit;

  // timer is held at its preset outside SETTLE so every combo starts fresh
  tt_settle_timer #(.W(8)) u_settle (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (state_q != SETTLE),
    .load_val_i (SETTLE_LD),
    .en_i       (state_q == SETTLE),
    .expire_o   (settle_expire)
  );

`ifdef TT_MAJORITY_VOTE_EN
  logic [1:0] smp_q;
  logic [1:0] vote_q;

  // final of three sample cycles commits the majority of the observations
  always_comb begin
    sample_last = (smp_q == 2'd2);
    sample_bit  = maj3(vote_q[0], vote_q[1], dut_out);
  end

  // vote collection for the first two sample cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      smp_q  <= '0;
      vote_q <= '0;
    end else if (state_q != SAMPLE) begin
      smp_q  <= '0;
    end else if (!sample_last) begin
      vote_q[smp_q[0]] <= dut_out;
      smp_q            <= smp_q + 2'd1;
    end
  end
`else
  // single-cycle sample: the gate output is committed directly
  always_comb begin
    sample_last = 1'b1;
    sample_bit  = dut_out;
  end
`endif

  // main sweep FSM with registered outputs; abort outranks every transition
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      dut_in_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      valid_q  <= 1'b0;
      code_q   <= '0;
    end else begin
      done_q <= 1'b0;
      if ((state_q != IDLE) && abort) begin
        state_q  <= IDLE;
        idx_q    <= '0;
        dut_in_q <= '0;
        busy_q   <= 1'b0;
        valid_q  <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (start && !abort) begin
              state_q  <= SETTLE;
              idx_q    <= '0;
              dut_in_q <= '0;
              busy_q   <= 1'b1;
              valid_q  <= 1'b0;
            end
          end
          SETTLE: begin
            if (settle_expire) state_q <= SAMPLE;
          end
          SAMPLE: begin
            if (sample_last) begin
              code_q[LAST_IDX - idx_q] <= sample_bit;
              if (idx_q == LAST_IDX) begin
                state_q  <= FINISH;
                dut_in_q <= '0;
                done_q   <= 1'b1;
                valid_q  <= 1'b1;
              end else begin
                state_q  <= SETTLE;
                idx_q    <= idx_q + 1'b1;
                dut_in_q <= idx_q + 1'b1;
              end
            end
          end
          FINISH: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign dut_in = dut_in_q;
  assign busy   = busy_q;
  // an abort arriving during FINISH suppresses the completion pulse
  assign done   = done_q & ~abort;
  assign code   = code_q;
  assign valid  = valid_q;

endmodule
